// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register: owns the PC, applies ID redirects,
// stall hold, wrong-path flush and edge-triggered interrupt entry with EPC capture.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] IRQ_PC   = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        intterupt,
  input  logic [2:0]  PCSrcID,
  input  logic [31:0] branchaddrID,
  input  logic [31:0] jumpaddrID,
  input  logic [31:0] jraddrID,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instructionID,
  output logic [31:0] PCplus4ID,
  output logic [31:0] epc,
  output logic        in_irq,
  output logic        irq_ack
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] epc_q, epc_d;
  logic        in_irq_q, in_irq_d;
  logic        irq_prev_q, irq_prev_d;
  logic        pending_q, pending_d;
  logic        irq_ack_q, irq_ack_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        entry;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    redirect = (PCSrcID >= 3'd1) && (PCSrcID <= 3'd4);
    entry    = !stall && !redirect && pending_q && !in_irq_q;

    case (PCSrcID)
      3'd1:    target = branchaddrID;
      3'd2:    target = jumpaddrID;
      3'd3:    target = jraddrID;
      default: target = epc_q;
    endcase

    pc_d       = pc_q;
    instr_d    = instr_q;
    pcp4_d     = pcp4_q;
    epc_d      = epc_q;
    in_irq_d   = in_irq_q;
    irq_ack_d  = 1'b0;
    irq_prev_d = intterupt;
    // A fresh edge in the entry cycle must not be lost, so set wins over clear.
    pending_d  = (pending_q && !entry) || (intterupt && !irq_prev_q);

    if (!stall) begin
      if (redirect) begin
        pc_d    = {target[31:2], 2'b00};
        instr_d = 32'd0;
        pcp4_d  = 32'd0;
        if (PCSrcID == 3'd4) in_irq_d = 1'b0;
      end else if (entry) begin
        epc_d     = pc_q;
        pc_d      = IRQ_PC;
        in_irq_d  = 1'b1;
        irq_ack_d = 1'b1;
        instr_d   = 32'd0;
        pcp4_d    = 32'd0;
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        pcp4_d  = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pcp4_q     <= 32'd0;
      epc_q      <= 32'd0;
      in_irq_q   <= 1'b0;
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
      irq_ack_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pcp4_q     <= pcp4_d;
      epc_q      <= epc_d;
      in_irq_q   <= in_irq_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      irq_ack_q  <= irq_ack_d;
    end
  end

  assign imem_addr     = pc_q;
  assign instructionID = instr_q;
  assign PCplus4ID     = pcp4_q;
  assign epc           = epc_q;
  assign in_irq        = in_irq_q;
  assign irq_ack       = irq_ack_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-in-flight check, and
// randomized cycles compared against a behavioural reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IRQ_PC   = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        irq;
  logic [2:0]  src;
  logic [31:0] baddr, jaddr, raddr;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instructionID, PCplus4ID, epc;
  logic        in_irq, irq_ack;
  logic        mem_hash;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a, input logic h);
    return h ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234) : a;
  endfunction

  assign imem_rdata = mem(imem_addr, mem_hash);

  fetch_unit #(.RESET_PC(RESET_PC), .IRQ_PC(IRQ_PC)) dut (
    .clk(clk), .reset(reset_n), .stall(stall), .intterupt(irq), .PCSrcID(src),
    .branchaddrID(baddr), .jumpaddrID(jaddr), .jraddrID(raddr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instructionID(instructionID), .PCplus4ID(PCplus4ID), .epc(epc),
    .in_irq(in_irq), .irq_ack(irq_ack)
  );

  task automatic chk(input string nm, input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [31:0] e_p4, input logic [31:0] e_epc,
                     input logic e_ii, input logic e_ack);
    n_checks++;
    if ({imem_addr, instructionID, PCplus4ID, epc, in_irq, irq_ack} ===
        {e_pc, e_ins, e_p4, e_epc, e_ii, e_ack})
      n_pass++;
    else
      $display("FAIL %s: got pc=%h ins=%h p4=%h epc=%h in_irq=%b ack=%b, want pc=%h ins=%h p4=%h epc=%h in_irq=%b ack=%b",
               nm, imem_addr, instructionID, PCplus4ID, epc, in_irq, irq_ack,
               e_pc, e_ins, e_p4, e_epc, e_ii, e_ack);
  endtask

  task automatic drive(input logic s, input logic i, input logic [2:0] p, input logic [31:0] t);
    stall = s;
    irq   = i;
    src   = p;
    baddr = (p == 3'd1) ? t : 32'hBAD0_0010;
    jaddr = (p == 3'd2) ? t : 32'hBAD0_0020;
    raddr = (p == 3'd3) ? t : 32'hBAD0_0030;
  endtask

  typedef struct {
    logic        s;
    logic        i;
    logic [2:0]  p;
    logic [31:0] t;
    logic [31:0] pc, ins, p4, ep;
    logic        ii, ack;
  } vec_t;
  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_pc, m_ins, m_p4, m_epc;
  logic        m_ii, m_pend, m_prev, m_ack;

  task automatic model_reset();
    m_pc = RESET_PC; m_ins = 0; m_p4 = 0; m_epc = 0;
    m_ii = 0; m_pend = 0; m_prev = 0; m_ack = 0;
  endtask

  task automatic model_step(input logic s, input logic i, input logic [2:0] p,
                            input logic [31:0] b, input logic [31:0] j, input logic [31:0] r);
    logic edge_seen;
    logic [31:0] tgt;
    edge_seen = i && !m_prev;
    m_prev = i;
    m_ack = 0;
    if (s) begin
      // frozen
    end else if (p >= 1 && p <= 4) begin
      tgt = (p == 1) ? b : (p == 2) ? j : (p == 3) ? r : m_epc;
      m_pc = tgt & ~32'd3;
      if (p == 4) m_ii = 0;
      m_ins = 0; m_p4 = 0;
    end else if (m_pend && !m_ii) begin
      m_epc = m_pc; m_pc = IRQ_PC; m_ii = 1; m_pend = 0; m_ack = 1;
      m_ins = 0; m_p4 = 0;
    end else begin
      m_ins = mem(m_pc, 1'b1);
      m_pc = m_pc + 32'd4;
      m_p4 = m_pc;
    end
    if (edge_seen) m_pend = 1;
  endtask

  initial begin
    // stall, irq, src, target, -> pc, ins, p4, epc, in_irq, ack
    vecs.push_back('{0,0,3'd0,32'h0,        32'h4,  32'h0,  32'h4,  32'h0, 0,0});
    vecs.push_back('{0,0,3'd5,32'h300,      32'h8,  32'h4,  32'h8,  32'h0, 0,0});
    vecs.push_back('{0,0,3'd1,32'h40,       32'h40, 32'h0,  32'h0,  32'h0, 0,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h44, 32'h40, 32'h44, 32'h0, 0,0});
    vecs.push_back('{1,0,3'd2,32'h80,       32'h44, 32'h40, 32'h44, 32'h0, 0,0});
    vecs.push_back('{1,0,3'd2,32'h80,       32'h44, 32'h40, 32'h44, 32'h0, 0,0});
    vecs.push_back('{1,0,3'd2,32'h80,       32'h44, 32'h40, 32'h44, 32'h0, 0,0});
    vecs.push_back('{0,0,3'd2,32'h80,       32'h80, 32'h0,  32'h0,  32'h0, 0,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h84, 32'h80, 32'h84, 32'h0, 0,0});
    vecs.push_back('{0,0,3'd3,32'h103,      32'h100,32'h0,  32'h0,  32'h0, 0,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h104,32'h100,32'h104,32'h0, 0,0});
    vecs.push_back('{0,1,3'd2,32'h20,       32'h20, 32'h0,  32'h0,  32'h0, 0,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h4,  32'h0,  32'h0,  32'h20,1,1});
    vecs.push_back('{0,1,3'd0,32'h0,        32'h8,  32'h4,  32'h8,  32'h20,1,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'hC,  32'h8,  32'hC,  32'h20,1,0});
    vecs.push_back('{0,0,3'd4,32'h0,        32'h20, 32'h0,  32'h0,  32'h20,0,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h4,  32'h0,  32'h0,  32'h20,1,1});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h8,  32'h4,  32'h8,  32'h20,1,0});
    vecs.push_back('{0,0,3'd2,32'hFFFF_FFFF,32'hFFFF_FFFC,32'h0,32'h0,32'h20,1,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h0,  32'hFFFF_FFFC,32'h0,32'h20,1,0});
    vecs.push_back('{0,0,3'd4,32'h0,        32'h20, 32'h0,  32'h0,  32'h20,0,0});
    vecs.push_back('{0,0,3'd4,32'h0,        32'h20, 32'h0,  32'h0,  32'h20,0,0});
    vecs.push_back('{0,1,3'd0,32'h0,        32'h24, 32'h20, 32'h24, 32'h20,0,0});
    vecs.push_back('{1,0,3'd0,32'h0,        32'h24, 32'h20, 32'h24, 32'h20,0,0});
    vecs.push_back('{1,0,3'd0,32'h0,        32'h24, 32'h20, 32'h24, 32'h20,0,0});
    vecs.push_back('{0,0,3'd0,32'h0,        32'h4,  32'h0,  32'h0,  32'h24,1,1});

    mem_hash = 1'b0;
    drive(0, 0, 3'd0, 32'h0);
    reset_n = 1'b0;
    #12;
    chk("reset_state", RESET_PC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].s, vecs[k].i, vecs[k].p, vecs[k].t);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", k), vecs[k].pc, vecs[k].ins, vecs[k].p4,
          vecs[k].ep, vecs[k].ii, vecs[k].ack);
    end

    // Asynchronous reset in the middle of a redirect cycle
    drive(0, 1, 3'd1, 32'h0000_0040);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_redirect", RESET_PC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held_edge", RESET_PC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized phase against the reference model
    mem_hash = 1'b1;
    drive(0, 0, 3'd0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic s, i;
      logic [2:0] p;
      s = ($urandom_range(0, 4) == 0);
      i = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      stall = s;
      irq   = i;
      src   = p;
      baddr = $urandom;
      jaddr = $urandom;
      raddr = $urandom;
      model_step(s, i, p, baddr, jaddr, raddr);
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d", c), m_pc, m_ins, m_p4, m_epc, m_ii, m_ack);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
